spi_master_engine: RTL and testbench

- Byte-wide SPI master (mode 0, MSB first) that serialises CPU writes and returns received bytes to the CPU.
- Instantiated by the flash/SD port decoder, which drives enviar_dato/recibir_dato and din, and receives dout/oe_n.
- Shares one SCLK/MOSI pair between the config flash and the SD card; the MISO mux is upstream.
- ZXMMC/DIVMMC-style pipelined reads: finishing a CPU read automatically launches a 0xFF dummy transfer.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_master_engine.sv | 136 +++++++++++++
 tb/tb_spi_master_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master engine
// Contents: FSM state encoding, default idle byte, reset values of rx_buf and MOSI.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_t;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;
  localparam logic [7:0] RX_BUF_RST    = 8'hFF;
  localparam logic       MOSI_RST      = 1'b1;

endpackage

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - byte-wide SPI master, mode 0, MSB first, pipelined reads
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enviar_dato, din  CPU write strobe (level) and write data
//   recibir_dato      CPU read strobe (level); its end launches an IDLE_BYTE transfer
//   dout, oe_n        last completed received byte, CPU output enable (active low)
//   busy              transfer in progress
//   spi_clk, spi_di   SCLK (idles low) and MOSI
//   spi_do            MISO from the selected slave
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1,
  parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enviar_dato,
  input  logic       recibir_dato,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_di,
  input  logic       spi_do
);

  localparam logic [3:0] DIV_LAST = 4'(HALF_PERIOD - 1);

  spi_state_t state;
  logic       en_q, rd_q;
  logic       pend_v;
  logic [7:0] pend_d;
  logic [6:0] tx_sh;          // bits still to be sent after the one on spi_di
  logic [7:0] rx_sh;
  logic [7:0] rx_buf;
  logic [2:0] bit_cnt;
  logic [3:0] div_cnt;

  logic       wr_rise, rd_fall, new_req, last_edge, consume;
  logic [7:0] new_data;

  always_comb begin
    wr_rise   = enviar_dato & ~en_q;
    rd_fall   = rd_q & ~recibir_dato;
    new_req   = wr_rise | rd_fall;
    // A write edge in the same cycle as a read end wins; the dummy read is dropped.
    new_data  = wr_rise ? din : IDLE_BYTE;
    last_edge = (state == ST_HIGH) && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);
    consume   = pend_v && ((state == ST_IDLE) || last_edge);
  end

  assign dout = rx_buf;
  assign oe_n = rst | ~recibir_dato;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      pend_v  <= 1'b0;
      pend_d  <= 8'h00;
      tx_sh   <= 7'h00;
      rx_sh   <= 8'h00;
      rx_buf  <= RX_BUF_RST;
      bit_cnt <= 3'd0;
      div_cnt <= 4'd0;
      busy    <= 1'b0;
      spi_clk <= 1'b0;
      spi_di  <= MOSI_RST;
    end else begin
      en_q <= enviar_dato;
      rd_q <= recibir_dato;

      // A fresh request overwrites the pending slot even as the old one is taken.
      if (new_req) begin
        pend_v <= 1'b1;
        pend_d <= new_data;
      end else if (consume) begin
        pend_v <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pend_v) begin
            state   <= ST_LOW;
            tx_sh   <= pend_d[6:0];
            spi_di  <= pend_d[7];
            bit_cnt <= 3'd0;
            div_cnt <= 4'd0;
            busy    <= 1'b1;
          end
        end
        ST_LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 4'd0;
            state   <= ST_HIGH;
            spi_clk <= 1'b1;
            rx_sh   <= {rx_sh[6:0], spi_do};
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        ST_HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 4'd0;
            spi_clk <= 1'b0;
            if (bit_cnt != 3'd7) begin
              state   <= ST_LOW;
              spi_di  <= tx_sh[6];
              tx_sh   <= {tx_sh[5:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              rx_buf <= rx_sh;
              if (pend_v) begin
                // Chain straight into the queued byte with no idle cycle.
                state   <= ST_LOW;
                tx_sh   <= pend_d[6:0];
                spi_di  <= pend_d[7];
                bit_cnt <= 3'd0;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - scoreboard bench for spi_master_engine
module tb_spi_master_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       enviar_dato, recibir_dato;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n, busy, spi_clk, spi_di;
  logic       spi_do;

  logic       enviar3, recibir3;
  logic [7:0] din3, dout3;
  logic       oe_n3, busy3, spi_clk3, spi_di3;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_tx_q[$];
  logic [7:0] rep_q[$];
  int         n_done = 0;

  int         s_cnt;
  logic       s_prev, s_chk;
  logic [7:0] s_mosi;
  logic [7:0] s_cur;

  always #5 clk = ~clk;

  spi_master_engine #(.HALF_PERIOD(1)) u_dut (
    .clk(clk), .rst(rst), .enviar_dato(enviar_dato), .recibir_dato(recibir_dato),
    .din(din), .dout(dout), .oe_n(oe_n), .busy(busy),
    .spi_clk(spi_clk), .spi_di(spi_di), .spi_do(spi_do)
  );

  spi_master_engine #(.HALF_PERIOD(3)) u_dut3 (
    .clk(clk), .rst(rst), .enviar_dato(enviar3), .recibir_dato(recibir3),
    .din(din3), .dout(dout3), .oe_n(oe_n3), .busy(busy3),
    .spi_clk(spi_clk3), .spi_di(spi_di3), .spi_do(spi_di3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_xfer(input logic [7:0] tx, input logic [7:0] reply);
    exp_tx_q.push_back(tx);
    rep_q.push_back(reply);
  endtask

  // Slave model and scoreboard: samples MOSI on SCLK rise, supplies the queued
  // reply MSB first, and checks each finished byte when SCLK falls after bit 8.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      s_cnt  = 0;
      s_prev = 1'b0;
      s_chk  = 1'b0;
    end else begin
      if (spi_clk && !s_prev) begin
        s_mosi = {s_mosi[6:0], spi_di};
        if (s_cnt == 7) begin
          s_cnt = 0;
          s_chk = 1'b1;
        end else begin
          s_cnt++;
        end
      end
      if (!spi_clk && s_prev && s_chk) begin
        s_chk = 1'b0;
        if (n_done < exp_tx_q.size()) begin
          check_val($sformatf("mosi_byte_%0d", n_done), s_mosi, exp_tx_q[n_done]);
          check_val($sformatf("dout_byte_%0d", n_done), dout, rep_q[n_done]);
        end else begin
          check_val("unexpected_xfer", n_done, exp_tx_q.size());
        end
        n_done++;
      end
      s_prev = spi_clk;
    end
    s_cur  = (n_done < rep_q.size()) ? rep_q[n_done] : 8'hFF;
    spi_do = s_cur[7 - s_cnt];
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, (n < 200), 1'b1);
  endtask

  initial begin
    int cnt;
    int rises;
    rst = 1'b1;
    enviar_dato = 1'b0; recibir_dato = 1'b1; din = 8'h00;
    enviar3 = 1'b0; recibir3 = 1'b0; din3 = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_spi_clk", spi_clk, 1'b0);
    check_val("rst_spi_di", spi_di, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_dout", dout, 8'hFF);
    check_val("rst_oe_n", oe_n, 1'b1);
    recibir_dato = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0xA5, slave replies 0x3C: cycle-exact SCLK/busy timing.
    expect_xfer(8'hA5, 8'h3C);
    din = 8'hA5; enviar_dato = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("hp1_busy_%0d", k), busy, (k <= 16));
      check_val($sformatf("hp1_sclk_%0d", k), spi_clk, ((k % 2 == 0) && (k <= 16)));
      if (k == 1)  check_val("hp1_first_mosi", spi_di, 1'b1);
      if (k == 17) check_val("hp1_dout", dout, 8'h3C);
    end
    @(negedge clk);
    enviar_dato = 1'b0;
    repeat (2) @(negedge clk);

    // CPU read: dout shown while strobed, dummy 0xFF transfer on its end.
    expect_xfer(8'hFF, 8'h81);
    recibir_dato = 1'b1;
    #1;
    check_val("rd_oe_n_low", oe_n, 1'b0);
    check_val("rd_dout", dout, 8'h3C);
    repeat (3) @(negedge clk);
    check_val("rd_no_start", busy, 1'b0);
    recibir_dato = 1'b0;
    #1;
    check_val("rd_oe_n_high", oe_n, 1'b1);
    repeat (2) @(negedge clk);
    check_val("rd_started", busy, 1'b1);
    wait_idle("rd_timeout");
    check_val("rd_dout_after", dout, 8'h81);
    repeat (2) @(negedge clk);

    // Back-to-back writes: 0x33 replaces 0x11 in the pending slot.
    expect_xfer(8'h22, 8'h01);
    expect_xfer(8'h33, 8'h02);
    din = 8'h22; enviar_dato = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      case (k)
        1: enviar_dato = 1'b0;
        3: begin din = 8'h11; enviar_dato = 1'b1; end
        4: enviar_dato = 1'b0;
        6: begin din = 8'h33; enviar_dato = 1'b1; end
        7: enviar_dato = 1'b0;
        default: ;
      endcase
    end
    check_val("pend_busy_cycles", cnt, 32);
    check_val("pend_dout", dout, 8'h02);

    // Write rise and read fall in the same cycle: only the write goes out.
    recibir_dato = 1'b1;
    repeat (2) @(negedge clk);
    expect_xfer(8'h5A, 8'hC3);
    recibir_dato = 1'b0; enviar_dato = 1'b1; din = 8'h5A;
    repeat (2) @(negedge clk);
    enviar_dato = 1'b0;
    wait_idle("sim_timeout");
    check_val("sim_dout", dout, 8'hC3);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check_val("sim_no_dummy", cnt, 0);
    check_val("all_xfers_done", n_done, exp_tx_q.size());

    // Asynchronous reset at the 4th SCLK rise of a write.
    din = 8'hA5; enviar_dato = 1'b1;
    rises = 0;
    cnt = 0;
    while (rises < 4 && cnt < 60) begin
      @(posedge clk); #1;
      if (spi_clk) rises++;
      cnt++;
    end
    check_val("rstmid_reached", rises, 4);
    #1;
    rst = 1'b1;
    #1;
    check_val("rstmid_spi_clk", spi_clk, 1'b0);
    check_val("rstmid_spi_di", spi_di, 1'b1);
    check_val("rstmid_busy", busy, 1'b0);
    check_val("rstmid_dout", dout, 8'hFF);
    check_val("rstmid_oe_n", oe_n, 1'b1);
    enviar_dato = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // HALF_PERIOD=3 with MOSI looped to MISO: 3-cycle phases, 48-cycle byte.
    din3 = 8'hA5; enviar3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("hp3_sclk_%0d", k), spi_clk3, ((k <= 48) && (((k - 1) / 3) % 2 == 1)));
      if (k == 1)  check_val("hp3_busy_start", busy3, 1'b1);
      if (k == 48) check_val("hp3_busy_end", busy3, 1'b1);
      if (k == 49) begin
        check_val("hp3_busy_done", busy3, 1'b0);
        check_val("hp3_dout", dout3, 8'hA5);
      end
    end
    enviar3 = 1'b0;
    repeat (4) @(negedge clk);
    check_val("final_xfer_count", n_done, exp_tx_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
